// File: rtl/mem_bus_if_if.sv
// Request/response and external-memory control signals of the CPU bus interface unit.
// The bidirectional data pins stay a plain port on the unit itself.
interface mem_bus_if_if;
  logic       req;
  logic       we;
  logic [7:0] addr_l;
  logic [7:0] addr_h;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] mem_addr_l;
  logic [7:0] mem_addr_h;
  logic       mem_read;
  logic       mem_write;
  logic       mem_ready;

  modport slave (
    input  req, we, addr_l, addr_h, wdata, mem_ready,
    output rdata, busy, done, err, mem_addr_l, mem_addr_h, mem_read, mem_write
  );

  modport master (
    output req, we, addr_l, addr_h, wdata, mem_ready,
    input  rdata, busy, done, err, mem_addr_l, mem_addr_h, mem_read, mem_write
  );
endinterface

// File: rtl/mem_bus_if.sv
// 2A03 bus interface unit: latches a CPU request, runs a strobed, wait-stated
// external access with ready stretching and a bounded timeout, then pulses done.
module mem_bus_if #(
  parameter int WAIT_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bus_if_if.slave   bus,
  inout  wire [7:0]     mem_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t     state_q, state_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] addr_l_q, addr_l_d;
  logic [7:0] addr_h_q, addr_h_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       accept;
  logic       timeout;

  assign accept  = bus.req && ((state_q == IDLE) || (state_q == DONE));
  // WAIT_MAX of 0 wraps the compare value, so the guard is what disables the timeout.
  assign timeout = (WAIT_MAX != 0) && (wcnt_q == 8'(WAIT_MAX - 1)) && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
      addr_l_q <= 8'h00;
      addr_h_q <= 8'h00;
      rdata_q  <= 8'h00;
      wcnt_q   <= 8'h00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      addr_l_q <= addr_l_d;
      addr_h_q <= addr_h_d;
      rdata_q  <= rdata_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req) state_d = ACCESS;
      ACCESS:  if (bus.mem_ready || timeout) state_d = DONE;
      DONE:    state_d = bus.req ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d     = we_q;
    wdata_d  = wdata_q;
    addr_l_d = addr_l_q;
    addr_h_d = addr_h_q;
    rdata_d  = rdata_q;
    wcnt_d   = wcnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (accept) begin
      we_d     = bus.we;
      wdata_d  = bus.wdata;
      addr_l_d = bus.addr_l;
      addr_h_d = bus.addr_h;
      wcnt_d   = 8'h00;
    end
    if (state_q == ACCESS) begin
      if (bus.mem_ready) begin
        if (!we_q) rdata_d = mem_data;
        done_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 8'h01;
        done_d = timeout;
        err_d  = timeout;
      end
    end
    // Strobes are registered from the next state so they line up with ACCESS.
    rd_d = (state_d == ACCESS) && !we_d;
    wr_d = (state_d == ACCESS) && we_d;
  end

  assign bus.rdata      = rdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.mem_addr_l = addr_l_q;
  assign bus.mem_addr_h = addr_h_q;
  assign bus.mem_read   = rd_q;
  assign bus.mem_write  = wr_q;
  assign mem_data       = wr_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed bench for mem_bus_if with a scoreboard of expected completions.
module tb_mem_bus_if;
  localparam logic [7:0] PROBE = 8'h81;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       tb_drv;
  logic [7:0] tb_val;
  wire  [7:0] mem_data;
  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  assign mem_data = tb_drv ? tb_val : 8'hzz;

  mem_bus_if_if bus ();

  mem_bus_if #(.WAIT_MAX(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .mem_data (mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Status bundle {busy, done, err, mem_read, mem_write}; a done pulse pops the scoreboard.
  task automatic sample(input string tag, input logic eb, input logic ed, input logic ee,
                        input logic erd, input logic ewr);
    exp_t e;
    chk(tag, 16'({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write}),
        16'({eb, ed, ee, erd, ewr}));
    if (bus.done === 1'b1) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL %s_sb done observed=1 expected no pending access", tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_err"}, 16'(bus.err), 16'(e.err));
        chk({tag, "_rdata"}, 16'(bus.rdata), 16'(e.rdata));
      end
    end
  endtask

  task automatic chk_hiz(input string tag);
    tb_drv = 1'b1;
    tb_val = PROBE;
    #1;
    chk(tag, 16'(mem_data), 16'(PROBE));
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.addr_l    = 8'h00;
    bus.addr_h    = 8'h00;
    bus.wdata     = 8'h00;
    bus.mem_ready = 1'b0;
    tb_drv        = 1'b1;
    tb_val        = PROBE;
    #2 rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // Reset then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      cyc();
      sample("idle_status", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("idle_rdata", 16'(bus.rdata), 16'h0000);
      chk("idle_addr", {bus.mem_addr_h, bus.mem_addr_l}, 16'h0000);
      chk_hiz("idle_hiz");
    end

    // Zero-wait read from 0x3412 returning 0xA5.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr_l = 8'h12; bus.addr_h = 8'h34;
    bus.mem_ready = 1'b1; tb_val = 8'hA5;
    sb.push_back('{err: 1'b0, rdata: 8'hA5});
    cyc();
    sample("rd0_access", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rd0_addr", {bus.mem_addr_h, bus.mem_addr_l}, 16'h3412);
    bus.req = 1'b0;
    cyc();
    sample("rd0_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.mem_ready = 1'b0;
    cyc();
    sample("rd0_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rd0_addr_hold", {bus.mem_addr_h, bus.mem_addr_l}, 16'h3412);

    // Write 0x5C to 0x01FF with three wait states.
    bus.req = 1'b1; bus.we = 1'b1; bus.wdata = 8'h5C; bus.addr_l = 8'hFF; bus.addr_h = 8'h01;
    bus.mem_ready = 1'b0; tb_drv = 1'b0;
    sb.push_back('{err: 1'b0, rdata: 8'hA5});
    for (int k = 0; k < 4; k++) begin
      cyc();
      sample("wr_access", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("wr_addr", {bus.mem_addr_h, bus.mem_addr_l}, 16'h01FF);
      chk("wr_data", 16'(mem_data), 16'h005C);
      bus.req = 1'b0;
      if (k == 3) bus.mem_ready = 1'b1;
    end
    cyc();
    sample("wr_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_hiz("wr_done_hiz");
    bus.mem_ready = 1'b0;
    cyc();
    sample("wr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_hiz("wr_idle_hiz");

    // Timeout read: ready never arrives, strobe for 8 cycles, rdata kept.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr_l = 8'h00; bus.addr_h = 8'h80;
    tb_val = 8'h77;
    sb.push_back('{err: 1'b1, rdata: 8'hA5});
    for (int k = 0; k < 8; k++) begin
      cyc();
      sample("to_access", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.req = 1'b0;
    end
    cyc();
    sample("to_done", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    sample("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_rdata_kept", 16'(bus.rdata), 16'h00A5);

    // Three back-to-back zero-wait reads returning 0x01, 0x02, 0x03.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr_l = 8'h10; bus.addr_h = 8'h20;
    bus.mem_ready = 1'b1; tb_val = 8'h01;
    sb.push_back('{err: 1'b0, rdata: 8'h01});
    for (int n = 1; n <= 3; n++) begin
      cyc();
      sample("b2b_access", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("b2b_addr", {bus.mem_addr_h, bus.mem_addr_l}, 16'h2010 + 16'(n - 1));
      cyc();
      sample("b2b_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("b2b_rdata", 16'(bus.rdata), 16'(n));
      if (n < 3) begin
        tb_val     = 8'(n + 1);
        bus.addr_l = 8'h10 + 8'(n);
        sb.push_back('{err: 1'b0, rdata: 8'(n + 1)});
      end else begin
        bus.req = 1'b0;
      end
    end
    cyc();
    sample("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b2b_rdata_hold", 16'(bus.rdata), 16'h0003);
    bus.mem_ready = 1'b0;

    // Async reset during the second ACCESS cycle of a waited write.
    bus.req = 1'b1; bus.we = 1'b1; bus.wdata = 8'h3A; bus.addr_l = 8'h55; bus.addr_h = 8'h66;
    tb_drv = 1'b0;
    cyc();
    sample("rst_acc1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_acc1_data", 16'(mem_data), 16'h003A);
    bus.req = 1'b0;
    cyc();
    sample("rst_acc2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    sample("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_async_rdata", 16'(bus.rdata), 16'h0000);
    chk_hiz("rst_async_hiz");
    cyc();
    sample("rst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      sample("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_hiz("rst_after_hiz");
    end

    chk("sb_drained", 16'(sb.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
